ghost_move_controller: RTL

GHOST_MOVE_CONTROLLER -- requirements
Module: ghost_move_controller

---
 rtl/ghost_move_controller_pkg.sv | 70 +++++++
 rtl/ghost_square_object.sv | 37 +++
 rtl/ghost_move_controller.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ghost_move_controller_pkg.sv
// Shared constants and helpers for the ghost movement block.
// Contents: direction, game-mode and FSM-state enums; screen, ghost and tunnel geometry;
// a position struct; and the direction and step helper functions.
package ghost_move_controller_pkg;

  localparam int unsigned CoordW = 11;

  typedef logic [CoordW-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } pos_t;

  // Heading codes. The same encoding is used on next_dir and orientation.
  typedef enum logic [1:0] {
    DirUp    = 2'b00,
    DirDown  = 2'b01,
    DirLeft  = 2'b10,
    DirRight = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ModeScatter    = 2'b00,
    ModeChase      = 2'b01,
    ModeFrightened = 2'b10,
    ModeEaten      = 2'b11
  } game_mode_e;

  typedef enum logic [1:0] {
    StHouse  = 2'b00,
    StRoam   = 2'b01,
    StRevert = 2'b10
  } ghost_state_e;

  localparam int unsigned ScreenWidth = 640;
  localparam int unsigned GhostSize   = 16;
  // Rightmost top-left X at which the whole ghost is still on screen.
  localparam coord_t      TunnelLimit = coord_t'(ScreenWidth - GhostSize);

  // Reversing a heading only flips bit 0 of the code.
  function automatic dir_e dir_reverse(input dir_e d);
    return dir_e'({d[1], ~d[0]});
  endfunction

  function automatic dir_e dir_rotate_cw(input dir_e d);
    dir_e r;
    case (d)
      DirUp:    r = DirRight;
      DirRight: r = DirDown;
      DirDown:  r = DirLeft;
      default:  r = DirUp;
    endcase
    return r;
  endfunction

  // One step of spd pixels along d. X wraps through the side tunnel; Y does not wrap.
  function automatic pos_t pos_step(input pos_t p, input dir_e d, input coord_t spd);
    pos_t r;
    r = p;
    case (d)
      DirUp:    r.y = p.y - spd;
      DirDown:  r.y = p.y + spd;
      DirLeft:  r.x = (p.x < spd) ? TunnelLimit : p.x - spd;
      default:  r.x = (p.x > TunnelLimit - spd) ? '0 : p.x + spd;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ghost_square_object.sv
// Hit box for a 16x16 ghost sprite.
// Inputs:  pixelX/pixelY (current scan position), topLeftX/topLeftY (registered ghost corner).
// Outputs: in_container (pixel lies inside the box), offset_x/offset_y (pixel position inside
//          the box, 0..15; both 0 when outside). Purely combinational.
module ghost_square_object
  import ghost_move_controller_pkg::*;
(
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic [10:0] topLeftX,
  input  logic [10:0] topLeftY,
  output logic        in_container,
  output logic [10:0] offset_x,
  output logic [10:0] offset_y
);

  // One extra bit so a box near the top of the coordinate range does not wrap.
  logic [CoordW:0] right_edge;
  logic [CoordW:0] bottom_edge;
  logic            inside_x;
  logic            inside_y;

  always_comb begin
    right_edge   = {1'b0, topLeftX} + (CoordW+1)'(GhostSize - 1);
    bottom_edge  = {1'b0, topLeftY} + (CoordW+1)'(GhostSize - 1);
    inside_x     = (pixelX >= topLeftX) && ({1'b0, pixelX} <= right_edge);
    inside_y     = (pixelY >= topLeftY) && ({1'b0, pixelY} <= bottom_edge);
    in_container = inside_x && inside_y;
    offset_x     = '0;
    offset_y     = '0;
    if (in_container) begin
      offset_x = pixelX - topLeftX;
      offset_y = pixelY - topLeftY;
    end
  end

endmodule

// File: rtl/ghost_move_controller.sv
// Ghost movement controller: keeps the ghost in its house until released, then roams one
// step per frame, backs off and turns on wall contact, reverses on frightened entry and
// wraps through the horizontal tunnel.
// Inputs:  clk, resetN (sync, active low), startOfFrame, pixelX/pixelY, game_mode,
//          next_dir/next_dir_valid (steering request), wall_hit, restart.
// Outputs: topLeftX/topLeftY/orientation (registered), in_container, offset_x, offset_y.
module ghost_move_controller
  import ghost_move_controller_pkg::*;
#(
  parameter logic [1:0]  GHOSTNUM       = 2'd0,
  parameter logic [10:0] HOME_X         = 11'd304,
  parameter logic [10:0] HOME_Y         = 11'd224,
  parameter logic [10:0] SPEED          = 11'd1,
  parameter logic [9:0]  RELEASE_FRAMES = 10'd60
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic [1:0]  game_mode,
  input  logic [1:0]  next_dir,
  input  logic        next_dir_valid,
  input  logic        wall_hit,
  input  logic        restart,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic [1:0]  orientation,
  output logic        in_container,
  output logic [10:0] offset_x,
  output logic [10:0] offset_y
);

  localparam pos_t        HomePos      = pos_t'{x: HOME_X, y: HOME_Y};
  localparam logic [11:0] ReleaseLimit = 12'(RELEASE_FRAMES) * 12'(GHOSTNUM);

  ghost_state_e state_q, state_d;
  pos_t         pos_q, pos_d;
  dir_e         dir_q, dir_d;
  logic [11:0]  cnt_q, cnt_d;
  dir_e         pend_q, pend_d;
  logic         pend_valid_q, pend_valid_d;
  logic         hit_q, hit_d;
  logic         rev_q, rev_d;
  logic         tog_q, tog_d;
  logic         mode_q;

  // Requests arriving in the same cycle as startOfFrame are served by that frame.
  logic fright_now;
  logic fright_entry;
  logic hit_now;
  logic rev_now;
  logic pend_valid_now;
  dir_e pend_now;

  always_comb begin
    fright_now     = (game_mode == ModeFrightened);
    fright_entry   = fright_now & ~mode_q;
    hit_now        = hit_q | wall_hit;
    rev_now        = rev_q | fright_entry;
    pend_valid_now = pend_valid_q | next_dir_valid;
    pend_now       = next_dir_valid ? dir_e'(next_dir) : pend_q;
  end

  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    dir_d        = dir_q;
    cnt_d        = cnt_q;
    pend_d       = pend_now;
    pend_valid_d = pend_valid_now;
    hit_d        = hit_now;
    rev_d        = rev_now;
    tog_d        = tog_q;
    if (startOfFrame) begin
      hit_d = 1'b0;
      rev_d = 1'b0;
      tog_d = ~tog_q;
      unique case (state_q)
        StHouse: begin
          // The frame that brings the count up to the limit releases the ghost and also
          // takes its first step upwards.
          cnt_d = cnt_q + 12'd1;
          if (cnt_d >= ReleaseLimit) begin
            state_d = StRoam;
            dir_d   = DirUp;
            pos_d   = pos_step(pos_q, DirUp, SPEED);
          end
        end
        StRoam: begin
          if (rev_now) begin
            dir_d = dir_reverse(dir_q);
          end else if (hit_now) begin
            pos_d   = pos_step(pos_q, dir_reverse(dir_q), SPEED);
            state_d = StRevert;
          end else begin
            if (pend_valid_now) begin
              dir_d        = pend_now;
              pend_valid_d = 1'b0;
            end
            // Frightened ghosts run at half rate.
            if (!fright_now || tog_q) begin
              pos_d = pos_step(pos_q, dir_d, SPEED);
            end
          end
        end
        StRevert: begin
          if (rev_now) begin
            dir_d = dir_reverse(dir_q);
          end else if (pend_valid_now) begin
            dir_d        = pend_now;
            pend_valid_d = 1'b0;
          end else begin
            dir_d = dir_rotate_cw(dir_q);
          end
          state_d = StRoam;
        end
        default: state_d = StHouse;
      endcase
      if (rev_now) begin
        pend_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q      <= StHouse;
      pos_q        <= HomePos;
      dir_q        <= DirUp;
      cnt_q        <= '0;
      pend_q       <= DirUp;
      pend_valid_q <= 1'b0;
      hit_q        <= 1'b0;
      rev_q        <= 1'b0;
      tog_q        <= 1'b0;
      mode_q       <= 1'b0;
    end else if (restart) begin
      state_q      <= StHouse;
      pos_q        <= HomePos;
      dir_q        <= DirUp;
      cnt_q        <= '0;
      pend_q       <= DirUp;
      pend_valid_q <= 1'b0;
      hit_q        <= 1'b0;
      rev_q        <= 1'b0;
      tog_q        <= 1'b0;
      // Keep tracking the mode so a restart does not fake a frightened entry.
      mode_q       <= fright_now;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      dir_q        <= dir_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      hit_q        <= hit_d;
      rev_q        <= rev_d;
      tog_q        <= tog_d;
      mode_q       <= fright_now;
    end
  end

  assign topLeftX    = pos_q.x;
  assign topLeftY    = pos_q.y;
  assign orientation = dir_q;

  ghost_square_object u_square (
    .pixelX       (pixelX),
    .pixelY       (pixelY),
    .topLeftX     (pos_q.x),
    .topLeftY     (pos_q.y),
    .in_container (in_container),
    .offset_x     (offset_x),
    .offset_y     (offset_y)
  );

endmodule
